// File: rtl/otg_hpi_master_if.sv
// Bundles the Avalon-MM slave side and the physical HPI pins of the OTG transactor.
// The master modport is the transactor's view; slave is the Nios/chip-side view.
interface otg_hpi_master_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        waitrequest;
   logic [1:0]  otg_addr;
   logic [15:0] otg_data_out;
   logic        otg_data_oe;
   logic [15:0] otg_data_in;
   logic        otg_cs_n;
   logic        otg_rd_n;
   logic        otg_wr_n;
   logic        otg_rst_n;

   modport master (
      input  address, chipselect, read, write, writedata, otg_data_in,
      output readdata, waitrequest, otg_addr, otg_data_out, otg_data_oe,
             otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n
   );

   modport slave (
      output address, chipselect, read, write, writedata, otg_data_in,
      input  readdata, waitrequest, otg_addr, otg_data_out, otg_data_oe,
             otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n
   );
endinterface

// File: rtl/otg_hpi_master.sv
// Avalon-MM to CY7C67200 HPI bus transactor: one timed HPI read/write per stalled
// Avalon request, plus a post-reset hold of the chip reset line.
module otg_hpi_master #(
   parameter int SETUP_CYCLES   = 1,
   parameter int STROBE_CYCLES  = 3,
   parameter int HOLD_CYCLES    = 1,
   parameter int RECOVER_CYCLES = 2,
   parameter int RESET_CYCLES   = 16
) (
   input  logic             clk,
   input  logic             reset,
   otg_hpi_master_if.master bus
);
   localparam int MAX_SS  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAX_HR  = (HOLD_CYCLES > RECOVER_CYCLES) ? HOLD_CYCLES : RECOVER_CYCLES;
   localparam int MAX_A   = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
   localparam int MAX_ALL = (MAX_A > RESET_CYCLES) ? MAX_A : RESET_CYCLES;
   localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

   localparam logic [CW-1:0] C_SETUP_LAST   = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] C_STROBE_LAST  = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] C_HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] C_RECOVER_LAST = CW'(RECOVER_CYCLES - 1);
   localparam logic [CW-1:0] C_RESET_LAST   = CW'(RESET_CYCLES - 1);

   localparam logic [2:0] ST_RST     = 3'd0;
   localparam logic [2:0] ST_IDLE    = 3'd1;
   localparam logic [2:0] ST_SETUP   = 3'd2;
   localparam logic [2:0] ST_STROBE  = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_RECOVER = 3'd6;

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_wr;
   logic [1:0]    r_addr;
   logic [15:0]   r_data_out;
   logic [15:0]   r_readdata;
   logic          r_oe;
   logic          r_cs_n;
   logic          r_rd_n;
   logic          r_wr_n;
   logic          r_rst_n;
   logic          w_req;
   logic          w_last;

   assign w_req           = bus.chipselect & (bus.read | bus.write);
   assign bus.waitrequest = w_req & (r_state != ST_DONE);

   assign bus.readdata     = r_readdata;
   assign bus.otg_addr     = r_addr;
   assign bus.otg_data_out = r_data_out;
   assign bus.otg_data_oe  = r_oe;
   assign bus.otg_cs_n     = r_cs_n;
   assign bus.otg_rd_n     = r_rd_n;
   assign bus.otg_wr_n     = r_wr_n;
   assign bus.otg_rst_n    = r_rst_n;

   // Single-cycle states report "last" permanently, so the counter enters every state at zero.
   always_comb begin
      w_last = 1'b1;
      case (r_state)
         ST_RST:     w_last = (r_cnt == C_RESET_LAST);
         ST_SETUP:   w_last = (r_cnt == C_SETUP_LAST);
         ST_STROBE:  w_last = (r_cnt == C_STROBE_LAST);
         ST_HOLD:    w_last = (r_cnt == C_HOLD_LAST);
         ST_RECOVER: w_last = (r_cnt == C_RECOVER_LAST);
         default:    w_last = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RST;
         r_cnt      <= '0;
         r_is_wr    <= 1'b0;
         r_addr     <= 2'd0;
         r_data_out <= 16'd0;
         r_readdata <= 16'd0;
         r_oe       <= 1'b0;
         r_cs_n     <= 1'b1;
         r_rd_n     <= 1'b1;
         r_wr_n     <= 1'b1;
         r_rst_n    <= 1'b0;
      end else begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         case (r_state)
            ST_RST: begin
               if (w_last) begin
                  r_rst_n <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               // Write wins when read and write are both asserted.
               if (w_req) begin
                  r_is_wr <= bus.write;
                  r_addr  <= bus.address;
                  r_oe    <= bus.write;
                  r_cs_n  <= 1'b0;
                  if (bus.write) r_data_out <= bus.writedata;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_last) begin
                  r_rd_n  <= r_is_wr;
                  r_wr_n  <= ~r_is_wr;
                  r_state <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (w_last) begin
                  r_rd_n  <= 1'b1;
                  r_wr_n  <= 1'b1;
                  if (!r_is_wr) r_readdata <= bus.otg_data_in;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_last) begin
                  r_cs_n  <= 1'b1;
                  r_oe    <= 1'b0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_RECOVER;
            ST_RECOVER: begin
               if (w_last) r_state <= ST_IDLE;
            end
            default: begin
               r_rst_n <= 1'b0;
               r_state <= ST_RST;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_otg_hpi_master.sv
// Scoreboarded bench for otg_hpi_master: a register-file model of the OTG chip sits on
// the HPI pins, and a monitor checks every completed Avalon access against a reference.
module tb_otg_hpi_master;
   localparam int S  = 1;
   localparam int T  = 3;
   localparam int H  = 1;
   localparam int R  = 2;
   localparam int RC = 16;

   typedef struct {
      bit          is_wr;
      logic [1:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   otg_hpi_master_if bus ();
   otg_hpi_master_if bus2 ();

   otg_hpi_master dut (.clk(clk), .reset(reset), .bus(bus));
   otg_hpi_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(5)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [15:0] ref_reg [4] = '{default: 16'h0};
   logic [15:0] chip_reg[4] = '{default: 16'h0};
   int n_chk = 0, n_pass = 0, cyc = 0, viol = 0, bus_acc = 0, exp_acc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // OTG chip model: latches a write on the rising wr_n edge while cs_n stays low.
   logic        p_wr_n = 1'b1;
   logic [1:0]  p_addr = 2'd0;
   logic [15:0] p_dat  = 16'h0;
   always @(negedge clk) begin
      if (!p_wr_n && bus.otg_wr_n === 1'b1 && bus.otg_cs_n === 1'b0) chip_reg[p_addr] = p_dat;
      p_wr_n = bus.otg_wr_n;
      p_addr = bus.otg_addr;
      p_dat  = bus.otg_data_out;
      bus.otg_data_in = (bus.otg_cs_n === 1'b0 && bus.otg_rd_n === 1'b0) ?
                        chip_reg[bus.otg_addr] : 16'($urandom);
   end

   int acc_start = 0, last_rise = 0, rd_lo = 0, wr_lo = 0;
   bit in_acc = 0, oe_seen = 0, had_acc = 0;
   always @(negedge clk) begin
      if (reset) begin
         in_acc = 0;
      end else begin
         if (!bus.otg_rd_n && !bus.otg_wr_n) viol++;
         if (bus.otg_cs_n && (!bus.otg_rd_n || !bus.otg_wr_n)) viol++;
         if (!bus.otg_cs_n && !in_acc) begin
            in_acc = 1; acc_start = cyc; rd_lo = 0; wr_lo = 0; oe_seen = 0; bus_acc++;
            if (had_acc && (cyc - last_rise) < 1 + R) viol++;
         end
         if (in_acc && bus.otg_cs_n) begin
            in_acc = 0; had_acc = 1; last_rise = cyc;
         end
         if (!bus.otg_cs_n) begin
            if (!bus.otg_rd_n) rd_lo++;
            if (!bus.otg_wr_n) wr_lo++;
            if (bus.otg_data_oe) oe_seen = 1;
         end
         if (bus.chipselect && (bus.read || bus.write) && !bus.waitrequest) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_e = sbq.pop_front();
               chk("latency", cyc - acc_start, S + T + H);
               chk("otg_addr", bus.otg_addr, mon_e.addr);
               if (mon_e.is_wr) begin
                  chk("wr_strobe_len", wr_lo, T);
                  chk("rd_strobe_on_write", rd_lo, 0);
                  chk("oe_on_write", oe_seen, 1);
                  chk("chip_reg_written", chip_reg[mon_e.addr], mon_e.data);
               end else begin
                  chk("rd_strobe_len", rd_lo, T);
                  chk("wr_strobe_on_read", wr_lo, 0);
                  chk("oe_on_read", oe_seen, 0);
                  chk("readdata", bus.readdata, mon_e.data);
               end
            end
         end
      end
   end

   task automatic idle_req();
      bus.chipselect = 0; bus.read = 0; bus.write = 0;
   endtask

   // Called #1 after a posedge; returns #1 after a posedge.
   task automatic do_acc(input bit cs, input bit rd, input bit wr, input logic [1:0] a,
                         input logic [15:0] d, input bit abort);
      bit   live = cs && (rd || wr);
      bit   ok   = 0;
      exp_t e;
      if (live && !abort) begin
         e.is_wr = wr; e.addr = a; e.data = wr ? d : ref_reg[a];
         sbq.push_back(e);
      end
      if (live && wr) ref_reg[a] = d;
      if (live) exp_acc++;
      bus.chipselect = cs; bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
      if (!live) begin
         repeat (4) @(posedge clk);
         #1 idle_req();
      end else if (abort) begin
         for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); ok = !bus.otg_cs_n; end
         chk("abort_started", ok, 1);
         @(posedge clk); #1 idle_req();
         ok = 0;
         for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); ok = bus.otg_cs_n; end
         chk("abort_completed", ok, 1);
         @(posedge clk); #1;
      end else begin
         for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); ok = !bus.waitrequest; end
         chk("done_seen", ok, 1);
         @(posedge clk); #1 idle_req();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int lo, wrl, rdl, done_at;
      bit bad, dbad;
      idle_req();
      bus.address = 0; bus.writedata = 0;
      bus2.chipselect = 0; bus2.read = 0; bus2.write = 0;
      bus2.address = 0; bus2.writedata = 0; bus2.otg_data_in = 16'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", bus.otg_cs_n, 1);
      chk("rst_rd_n", bus.otg_rd_n, 1);
      chk("rst_wr_n", bus.otg_wr_n, 1);
      chk("rst_oe", bus.otg_data_oe, 0);
      chk("rst_addr", bus.otg_addr, 0);
      chk("rst_data_out", bus.otg_data_out, 0);
      chk("rst_readdata", bus.readdata, 0);
      chk("rst_otg_rst_n", bus.otg_rst_n, 0);
      @(posedge clk); #1 reset = 0;

      fork
         begin
            lo = 0; bad = 0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (bus.otg_rst_n !== 1'b0) break;
               lo++;
               if (bus.chipselect && !bus.waitrequest) bad = 1;
            end
            chk("rst_low_cycles", lo, RC);
            chk("stall_during_rst", bad, 0);
         end
         begin
            repeat (5) @(posedge clk);
            #1 do_acc(1, 0, 1, 2'd2, 16'h1234, 0);
         end
      join

      do_acc(1, 0, 1, 2'd0, 16'hBEEF, 0);
      do_acc(1, 1, 0, 2'd0, 16'h0000, 0);
      do_acc(1, 0, 1, 2'd3, 16'h0001, 0);
      do_acc(1, 0, 1, 2'd1, 16'hCE00, 0);
      do_acc(1, 1, 0, 2'd3, 16'h0000, 0);
      do_acc(1, 1, 1, 2'd1, 16'h00AA, 0);
      do_acc(1, 1, 0, 2'd1, 16'h0000, 0);
      do_acc(0, 1, 0, 2'd2, 16'h0000, 0);
      do_acc(1, 1, 0, 2'd2, 16'h0000, 0);

      for (int k = 0; k < 60; k++) begin
         bit cs, rd, wr, ab;
         cs = ($urandom_range(7) != 0);
         rd = $urandom_range(1);
         wr = !rd || ($urandom_range(3) == 0);
         ab = cs && ($urandom_range(5) == 0);
         if ($urandom_range(2) == 0) repeat ($urandom_range(3)) begin @(posedge clk); #1; end
         do_acc(cs, rd, wr, 2'($urandom_range(3)), 16'($urandom), ab);
      end

      // Reset lands in the middle of a write strobe; the write must be discarded.
      bus.chipselect = 1; bus.read = 0; bus.write = 1; bus.address = 2'd1; bus.writedata = 16'h5555;
      exp_acc++;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); ok = !bus.otg_wr_n; end
      chk("strobe_reached", ok, 1);
      reset = 1; idle_req();
      @(posedge clk); #1;
      chk("abort_wr_n", bus.otg_wr_n, 1);
      chk("abort_cs_n", bus.otg_cs_n, 1);
      chk("abort_oe", bus.otg_data_oe, 0);
      chk("abort_otg_rst_n", bus.otg_rst_n, 0);
      @(posedge clk); #1 reset = 0;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = bus.otg_rst_n && bus2.otg_rst_n; end
      chk("rst_released_again", ok, 1);
      @(posedge clk); #1;
      do_acc(1, 1, 0, 2'd1, 16'h0000, 0);

      // Overridden timing on the second instance with read and write both requested.
      bus2.chipselect = 1; bus2.read = 1; bus2.write = 1; bus2.address = 2'd1; bus2.writedata = 16'h00AA;
      wrl = 0; rdl = 0; done_at = -1; dbad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus2.otg_wr_n) begin
            wrl++;
            if (bus2.otg_data_out !== 16'h00AA || bus2.otg_data_oe !== 1'b1 || bus2.otg_addr !== 2'd1) dbad = 1;
         end
         if (!bus2.otg_rd_n) rdl++;
         if (!bus2.waitrequest) begin done_at = i; break; end
      end
      chk("p2_done_cycle", done_at, 9);
      chk("p2_wr_strobe_len", wrl, 5);
      chk("p2_rd_strobe", rdl, 0);
      chk("p2_bus_values", dbad, 0);
      @(posedge clk); #1;
      bus2.chipselect = 0; bus2.read = 0; bus2.write = 0;

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("bus_accesses", bus_acc, exp_acc);
      chk("protocol_violations", viol, 0);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
